serial_nibble_loader: RTL and testbench
=======================================

# serial_nibble_loader

Serial-to-parallel front end that sits directly upstream of the 4-bit register with synchronous set/reset/load. It collects a serial bit stream qualified by a valid strobe, assembles WIDTH-bit frames, and presents each completed frame on a parallel data bus with a one-cycle load pulse. It also turns host set/clear commands into one-cycle set/reset pulses for the register. Partial frames are discarded on timeout, abort, or command collision.

## Interface
Parameters:
- WIDTH, 4: frame width in bits; must equal the downstream register width.
- MSB_FIRST, 1: 1 = first received bit lands in d_out[WIDTH-1]; 0 = first bit lands in d_out[0].
- TIMEOUT, 8: idle cycles allowed between accepted bits of a partial frame, range 1..255.

Ports:
- Clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- sin, input, 1: serial data bit.
- sin_valid, input, 1: sin is accepted on any rising edge where this is high.
- abort, input, 1: discards the partial frame.
- cmd_set, input, 1: host request to set the register to all ones.
- cmd_clear, input, 1: host request to clear the register.
- d_out, output, WIDTH: last completed frame; drives the register D.
- load_out, output, 1: one-cycle load strobe to the register.
- set_out, output, 1: one-cycle set strobe to the register.
- reg_reset_out, output, 1: one-cycle clear strobe to the register.
- busy, output, 1: high while a partial frame is held.
- frame_err, output, 1: one-cycle pulse when a partial or completed frame is dropped.

## Operation
- FSM states:
  - IDLE: bit_cnt = 0.
  - SHIFT: 0 < bit_cnt < WIDTH.
- IDLE -> SHIFT on an accepted bit.
- SHIFT -> IDLE on any of: frame completion, timeout, abort, or command.
- Shift register:
  - Each accepted bit shifts in per MSB_FIRST.
  - bit_cnt increments, width $clog2(WIDTH+1).
- Frame completion: the WIDTH-th accepted bit completes the frame.
  - On the same edge the assembled frame is copied to d_out, load_out is registered high for one cycle, and bit_cnt returns to 0.
- d_out holds its value between completions and never shows partial data.
- Timeout:
  - idle_cnt increments each SHIFT cycle without sin_valid and clears on an accepted bit.
  - When idle_cnt reaches TIMEOUT, the partial frame is discarded, frame_err pulses, and the FSM goes to IDLE.
- abort in SHIFT: discard, frame_err pulses, IDLE. abort in IDLE: no effect, no frame_err.
- Commands:
  - cmd_clear causes reg_reset_out to pulse on the next cycle.
  - cmd_set causes set_out to pulse, unless cmd_clear is also high, in which case only reg_reset_out pulses.
  - A command in SHIFT discards the partial frame with frame_err.
  - A command in the cycle a frame would complete drops that frame: load_out stays 0, d_out is unchanged, frame_err pulses.
- Simultaneous events:
  - abort together with sin_valid: abort wins and the bit is dropped.
  - Timeout is not counted in a cycle with sin_valid.
- Outputs are mutually exclusive: at most one of load_out, set_out, reg_reset_out is high in any cycle.

## Timing
- Reset values: d_out = 0, load_out = 0, set_out = 0, reg_reset_out = 0, busy = 0, frame_err = 0, bit_cnt = 0, idle_cnt = 0, state = IDLE.
- Reset mid-frame discards all state with no frame_err.
- Latency:
  - The last bit accepted at edge k gives load_out high after edge k, and the register captures at edge k+1.
  - A command sampled at edge k gives its strobe high after edge k.
- Back-to-back frames: a bit accepted in the cycle load_out is high counts as bit 1 of the next frame, so there is no bubble. Sustained throughput is one frame per WIDTH cycles.
- All outputs are registered.
- busy is high in SHIFT; it falls on the edge that completes or drops the frame.

## Structure
- Shared package:
  - state encoding constants (S_IDLE, S_SHIFT);
  - default WIDTH / TIMEOUT;
  - a clog2 helper.
- Sub-module nibble_shift_core holds the shift register and bit counter.
  - Inputs: shift_en, clr, sin.
  - Outputs: frame, cnt.
- The top level holds the FSM, idle counter, command logic, and output registers.

## Test plan
- Reset, then with WIDTH = 4 and MSB_FIRST = 1 shift 1,0,1,1 on consecutive cycles -> exactly one load_out pulse one cycle after the 4th bit, with d_out = 4'b1011. busy is high for cycles 1–3 only.
- MSB_FIRST = 0 with the same bits -> d_out = 4'b1101. Then 8 back-to-back bits 0,0,1,1,1,1,0,0 -> two loads 4 cycles apart, d_out = 4'b1100 then 4'b0011.
- Two bits, then no sin_valid for TIMEOUT = 8 cycles -> frame_err pulses at the 8th idle cycle, no load_out, d_out unchanged. The next 4 bits load normally.
- Two bits, then abort with sin_valid high -> frame_err, bit dropped, busy low. abort in IDLE -> no frame_err.
- cmd_set and cmd_clear together -> reg_reset_out only. cmd_set asserted on the 4th-bit cycle -> set_out pulse, no load_out, frame_err, d_out unchanged.
- reset asserted after the 3rd bit -> all outputs 0, no frame_err. The next 4-bit frame loads correctly.

Source files
------------

// File: rtl/serial_nibble_loader_pkg.sv
// Shared types and constants for the serial nibble loader slice.
// Pure declarations: no logic, no latency, no flow control.
package serial_nibble_loader_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_nibble_loader_shift.sv
// Shift register and bit counter; frame presents the register with the current sin already shifted in.
// Single-cycle update on shift_en; no backpressure, clr overrides shift_en.
module nibble_shift_core
  import serial_nibble_loader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = clog2(DEF_WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] frame,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;

  generate
    if (MSB_FIRST) begin : g_msb
      assign frame = {r_sreg[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign frame = {sin, r_sreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (shift_en) begin
      r_sreg <= frame;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/serial_nibble_loader.sv
// Serial-to-parallel front end for a WIDTH-bit register: frame load, set and clear strobes.
// Strobes appear one cycle after the sampling edge; no backpressure, commands and abort drop partial frames.
module serial_nibble_loader
  import serial_nibble_loader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             abort,
  input  logic             cmd_set,
  input  logic             cmd_clear,
  output logic [WIDTH-1:0] d_out,
  output logic             load_out,
  output logic             set_out,
  output logic             reg_reset_out,
  output logic             busy,
  output logic             frame_err
);

  localparam int CNT_W = clog2(WIDTH + 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_idle_cnt, w_idle_nxt;
  logic [WIDTH-1:0] w_frame;
  logic [CNT_W-1:0] w_cnt;
  logic w_shift_en, w_clr, w_last;
  logic w_load_nxt, w_set_nxt, w_rst_nxt, w_err_nxt;

  nibble_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .CNT_W    (CNT_W)
  ) u_core (
    .clk     (Clk),
    .reset   (reset),
    .shift_en(w_shift_en),
    .clr     (w_clr),
    .sin     (sin),
    .frame   (w_frame),
    .cnt     (w_cnt)
  );

  assign w_last = (w_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Commands and abort outrank a same-cycle bit, so a completing frame is dropped rather than loaded.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_shift_en  = 1'b0;
    w_clr       = 1'b0;
    w_load_nxt  = 1'b0;
    w_set_nxt   = cmd_set & ~cmd_clear;
    w_rst_nxt   = cmd_clear;
    w_err_nxt   = 1'b0;
    if (cmd_set || cmd_clear || abort) begin
      w_clr       = 1'b1;
      w_idle_nxt  = '0;
      w_state_nxt = S_IDLE;
      w_err_nxt   = (r_state == S_SHIFT);
    end else if (sin_valid) begin
      w_idle_nxt = '0;
      if (w_last) begin
        w_clr       = 1'b1;
        w_load_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_shift_en  = 1'b1;
        w_state_nxt = S_SHIFT;
      end
    end else if (r_state == S_SHIFT) begin
      if (r_idle_cnt == 8'(TIMEOUT - 1)) begin
        w_clr       = 1'b1;
        w_idle_nxt  = '0;
        w_err_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_idle_nxt = r_idle_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_idle_cnt    <= '0;
      d_out         <= '0;
      load_out      <= 1'b0;
      set_out       <= 1'b0;
      reg_reset_out <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      r_idle_cnt    <= w_idle_nxt;
      load_out      <= w_load_nxt;
      set_out       <= w_set_nxt;
      reg_reset_out <= w_rst_nxt;
      frame_err     <= w_err_nxt;
      if (w_load_nxt) d_out <= w_frame;
    end
  end

  assign busy = (r_state == S_SHIFT);

endmodule

// File: tb/tb_serial_nibble_loader.sv
// Directed bench: MSB-first and LSB-first instances share stimulus; each row checks both.
module tb_serial_nibble_loader;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic reset, sin, sin_valid, abort, cmd_set, cmd_clear;
  logic [3:0] m_d, l_d;
  logic m_ld, m_set, m_rr, m_busy, m_err;
  logic l_ld, l_set, l_rr, l_busy, l_err;

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b1), .TIMEOUT(8)) u_msb (
    .Clk(Clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .abort(abort),
    .cmd_set(cmd_set), .cmd_clear(cmd_clear), .d_out(m_d), .load_out(m_ld),
    .set_out(m_set), .reg_reset_out(m_rr), .busy(m_busy), .frame_err(m_err)
  );

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b0), .TIMEOUT(8)) u_lsb (
    .Clk(Clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .abort(abort),
    .cmd_set(cmd_set), .cmd_clear(cmd_clear), .d_out(l_d), .load_out(l_ld),
    .set_out(l_set), .reg_reset_out(l_rr), .busy(l_busy), .frame_err(l_err)
  );

  typedef struct {
    logic       rst, sv, s, ab, cs, cc;
    logic [4:0] flags;  // {load, set, reg_reset, busy, frame_err}
    logic [3:0] dm, dl;
  } vec_t;

  vec_t vecs[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {ld,set,rr,busy,err,d}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, sv, s, ab, cs, cc);
    reset = rst; sin_valid = sv; sin = s; abort = ab; cmd_set = cs; cmd_clear = cc;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic rst, sv, s, ab, cs, cc,
                     input logic [4:0] flags, input logic [3:0] dm, dl);
    vec_t v;
    v.rst = rst; v.sv = sv; v.s = s; v.ab = ab; v.cs = cs; v.cc = cc;
    v.flags = flags; v.dm = dm; v.dl = dl;
    vecs.push_back(v);
  endtask

  function automatic logic [8:0] obs_m();
    return {m_ld, m_set, m_rr, m_busy, m_err, m_d};
  endfunction

  function automatic logic [8:0] obs_l();
    return {l_ld, l_set, l_rr, l_busy, l_err, l_d};
  endfunction

  initial begin
    // rst sv s ab cs cc | ld set rr busy err | d msb | d lsb
    add(0,1,1,0,0,0, 5'b00010, 4'b0000, 4'b0000);
    add(0,1,0,0,0,0, 5'b00010, 4'b0000, 4'b0000);
    add(0,1,1,0,0,0, 5'b00010, 4'b0000, 4'b0000);
    add(0,1,1,0,0,0, 5'b10000, 4'b1011, 4'b1101);
    add(0,0,0,0,0,0, 5'b00000, 4'b1011, 4'b1101);
    // back-to-back 0,0,1,1,1,1,0,0
    add(0,1,0,0,0,0, 5'b00010, 4'b1011, 4'b1101);
    add(0,1,0,0,0,0, 5'b00010, 4'b1011, 4'b1101);
    add(0,1,1,0,0,0, 5'b00010, 4'b1011, 4'b1101);
    add(0,1,1,0,0,0, 5'b10000, 4'b0011, 4'b1100);
    add(0,1,1,0,0,0, 5'b00010, 4'b0011, 4'b1100);
    add(0,1,1,0,0,0, 5'b00010, 4'b0011, 4'b1100);
    add(0,1,0,0,0,0, 5'b00010, 4'b0011, 4'b1100);
    add(0,1,0,0,0,0, 5'b10000, 4'b1100, 4'b0011);
    add(0,0,0,0,0,0, 5'b00000, 4'b1100, 4'b0011);
    // abort with sin_valid mid-frame, then abort in idle
    add(0,1,1,0,0,0, 5'b00010, 4'b1100, 4'b0011);
    add(0,1,0,0,0,0, 5'b00010, 4'b1100, 4'b0011);
    add(0,1,1,1,0,0, 5'b00001, 4'b1100, 4'b0011);
    add(0,0,0,1,0,0, 5'b00000, 4'b1100, 4'b0011);
    add(0,0,0,0,0,0, 5'b00000, 4'b1100, 4'b0011);
    // commands: both -> clear only, then set alone
    add(0,0,0,0,1,1, 5'b00100, 4'b1100, 4'b0011);
    add(0,0,0,0,1,0, 5'b01000, 4'b1100, 4'b0011);
    add(0,0,0,0,0,0, 5'b00000, 4'b1100, 4'b0011);
    // cmd_set on the completing bit drops the frame
    add(0,1,0,0,0,0, 5'b00010, 4'b1100, 4'b0011);
    add(0,1,1,0,0,0, 5'b00010, 4'b1100, 4'b0011);
    add(0,1,1,0,0,0, 5'b00010, 4'b1100, 4'b0011);
    add(0,1,1,0,1,0, 5'b01001, 4'b1100, 4'b0011);
    add(0,0,0,0,0,0, 5'b00000, 4'b1100, 4'b0011);
    add(0,1,0,0,0,0, 5'b00010, 4'b1100, 4'b0011);
    add(0,1,1,0,0,0, 5'b00010, 4'b1100, 4'b0011);
    add(0,1,1,0,0,0, 5'b00010, 4'b1100, 4'b0011);
    add(0,1,0,0,0,0, 5'b10000, 4'b0110, 4'b0110);
    add(0,0,0,0,0,0, 5'b00000, 4'b0110, 4'b0110);
    // reset after the third bit, then a clean frame 1,0,0,0
    add(0,1,1,0,0,0, 5'b00010, 4'b0110, 4'b0110);
    add(0,1,1,0,0,0, 5'b00010, 4'b0110, 4'b0110);
    add(0,1,1,0,0,0, 5'b00010, 4'b0110, 4'b0110);
    add(1,0,0,0,0,0, 5'b00000, 4'b0000, 4'b0000);
    add(0,0,0,0,0,0, 5'b00000, 4'b0000, 4'b0000);
    add(0,1,1,0,0,0, 5'b00010, 4'b0000, 4'b0000);
    add(0,1,0,0,0,0, 5'b00010, 4'b0000, 4'b0000);
    add(0,1,0,0,0,0, 5'b00010, 4'b0000, 4'b0000);
    add(0,1,0,0,0,0, 5'b10000, 4'b1000, 4'b0001);
    add(0,0,0,0,0,0, 5'b00000, 4'b1000, 4'b0001);

    drive(1,0,0,0,0,0);
    step();
    step();
    check("reset_msb", obs_m(), 9'b0);
    check("reset_lsb", obs_l(), 9'b0);
    drive(0,0,0,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sv, vecs[i].s, vecs[i].ab, vecs[i].cs, vecs[i].cc);
      step();
      check($sformatf("vec%0d_msb", i), obs_m(), {vecs[i].flags, vecs[i].dm});
      check($sformatf("vec%0d_lsb", i), obs_l(), {vecs[i].flags, vecs[i].dl});
    end

    // Timeout: two bits, then eight idle cycles; error only on the eighth.
    drive(0,1,1,0,0,0); step();
    drive(0,1,1,0,0,0); step();
    drive(0,0,0,0,0,0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 8) begin
        check($sformatf("tmo_wait%0d_msb", k), obs_m(), {5'b00010, 4'b1000});
        check($sformatf("tmo_wait%0d_lsb", k), obs_l(), {5'b00010, 4'b0001});
      end else begin
        check("tmo_fire_msb", obs_m(), {5'b00001, 4'b1000});
        check("tmo_fire_lsb", obs_l(), {5'b00001, 4'b0001});
      end
    end
    step();
    check("tmo_after_msb", obs_m(), {5'b00000, 4'b1000});

    // Recovery frame 0,1,0,1.
    drive(0,1,0,0,0,0); step();
    drive(0,1,1,0,0,0); step();
    drive(0,1,0,0,0,0); step();
    check("rec_busy_msb", obs_m(), {5'b00010, 4'b1000});
    drive(0,1,1,0,0,0); step();
    check("rec_load_msb", obs_m(), {5'b10000, 4'b0101});
    check("rec_load_lsb", obs_l(), {5'b10000, 4'b1010});
    drive(0,0,0,0,0,0); step();
    check("rec_idle_msb", obs_m(), {5'b00000, 4'b0101});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
